// File: rtl/membus_arb_pkg.sv
// membus_arb shared types: bus widths, arbiter state, owner ids and
// the latched bus request bundle.
package membus_arb_pkg;

    localparam int W_ADDR = 32;
    localparam int W_DATA = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } arb_state_t;

    localparam logic ARB_I = 1'b0;
    localparam logic ARB_D = 1'b1;

    typedef struct packed {
        logic [W_ADDR-1:0] addr;
        logic [W_DATA-1:0] wdata;
        logic [3:0]        wstrb;
    } bus_req_t;

endpackage

// File: rtl/membus_arb_if.sv
// membus_arb_if: pipeline fetch/data ports plus the shared memory bus.
// slave = arbiter view, master = pipeline + memory environment view.
interface membus_arb_if;
    import membus_arb_pkg::*;

    logic              i_en;
    logic [W_ADDR-1:0] i_addr;
    logic [W_DATA-1:0] i_rdata;
    logic              i_stall;
    logic              d_en;
    logic [3:0]        d_we;
    logic [W_ADDR-1:0] d_addr;
    logic [W_DATA-1:0] d_wdata;
    logic [W_DATA-1:0] d_rdata;
    logic              d_stall;
    logic              pipe_adv;
    logic              bus_req;
    logic              bus_wr;
    logic [3:0]        bus_wstrb;
    logic [W_ADDR-1:0] bus_addr;
    logic [W_DATA-1:0] bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [W_DATA-1:0] bus_rdata;

    modport slave (
        input  i_en, i_addr, d_en, d_we, d_addr, d_wdata, pipe_adv,
        input  bus_addr_ok, bus_data_ok, bus_rdata,
        output i_rdata, i_stall, d_rdata, d_stall,
        output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata
    );

    modport master (
        output i_en, i_addr, d_en, d_we, d_addr, d_wdata, pipe_adv,
        output bus_addr_ok, bus_data_ok, bus_rdata,
        input  i_rdata, i_stall, d_rdata, d_stall,
        input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata
    );

endinterface

// File: rtl/membus_arb_port.sv
// membus_arb_port: one pipeline port's served flag, result buffer, stall.
// Ports: clk, rst, en_i, adv_i (retire), done_i (completion), rdata_i -> stall_o, rdata_o.
module membus_arb_port
    import membus_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              adv_i,
    input  logic              done_i,
    input  logic [W_DATA-1:0] rdata_i,
    output logic              stall_o,
    output logic [W_DATA-1:0] rdata_o
);

    logic              served_q, served_d;
    logic [W_DATA-1:0] buf_q, buf_d;

    always_comb begin
        served_d = served_q;
        buf_d    = buf_q;
        if (adv_i) served_d = 1'b0;
        // an in-flight completion still lands even if the pipe advanced
        if (done_i) begin
            served_d = 1'b1;
            buf_d    = rdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            served_q <= 1'b0;
            buf_q    <= '0;
        end else begin
            served_q <= served_d;
            buf_q    <= buf_d;
        end
    end

    assign stall_o = en_i & ~served_q;
    assign rdata_o = buf_q;

endmodule

// File: rtl/membus_arb.sv
// membus_arb: shares one SRAM-style bus between fetch and data ports.
// Ports: clk, rst (sync, active-high), bus (membus_arb_if.slave).
// MEMARB_RR_EN: alternate grants when both ports pend (else data wins).
module membus_arb
    import membus_arb_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    membus_arb_if.slave  bus
);

    arb_state_t state_q, state_d;
    logic       owner_q, owner_d;
    bus_req_t   req_q, req_d;
    logic       i_pend, d_pend, grant, win;
    logic       i_done, d_done;

    // pending == stalling: enabled and not yet served
    assign i_pend = bus.i_stall;
    assign d_pend = bus.d_stall;
    assign grant  = (state_q == S_IDLE) & (i_pend | d_pend);

`ifdef MEMARB_RR_EN
    logic last_q;

    always_comb begin
        win = d_pend ? ARB_D : ARB_I;
        if (i_pend && d_pend) win = ~last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) last_q <= ARB_I;
        else if (grant) last_q <= win;
    end
`else
    always_comb begin
        win = d_pend ? ARB_D : ARB_I;
    end
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        req_d   = req_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant) begin
                    owner_d = win;
                    state_d = S_ADDR;
                    if (win == ARB_D) begin
                        req_d.addr  = bus.d_addr;
                        req_d.wdata = bus.d_wdata;
                        req_d.wstrb = bus.d_we;
                    end else begin
                        req_d.addr  = bus.i_addr;
                        req_d.wdata = '0;
                        req_d.wstrb = 4'b0000;
                    end
                end
            end
            S_ADDR: if (bus.bus_addr_ok) state_d = S_DATA;
            S_DATA: if (bus.bus_data_ok) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= ARB_I;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            req_q   <= req_d;
        end
    end

    assign i_done = (state_q == S_DATA) & bus.bus_data_ok & (owner_q == ARB_I);
    assign d_done = (state_q == S_DATA) & bus.bus_data_ok & (owner_q == ARB_D);

    assign bus.bus_req   = (state_q == S_ADDR);
    assign bus.bus_wr    = |req_q.wstrb;
    assign bus.bus_wstrb = req_q.wstrb;
    assign bus.bus_addr  = req_q.addr;
    assign bus.bus_wdata = req_q.wdata;

    membus_arb_port u_iport (
        .clk     (clk),
        .rst     (rst),
        .en_i    (bus.i_en),
        .adv_i   (bus.pipe_adv),
        .done_i  (i_done),
        .rdata_i (bus.bus_rdata),
        .stall_o (bus.i_stall),
        .rdata_o (bus.i_rdata)
    );

    membus_arb_port u_dport (
        .clk     (clk),
        .rst     (rst),
        .en_i    (bus.d_en),
        .adv_i   (bus.pipe_adv),
        .done_i  (d_done),
        .rdata_i (bus.bus_rdata),
        .stall_o (bus.d_stall),
        .rdata_o (bus.d_rdata)
    );

endmodule
